// File: rtl/nios2_cpu_debug_cmd_bridge.sv
// JTAG debug command bridge: synchronises update-DR/IR, captures IR and data, and issues one-hot command strobes to the CPU.
// Optional acknowledge timeout is compiled in with NIOS2_DEBUG_CMD_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no command pending; a vs_udr rise captures sr and issues
// ST_ISSUE  | strobe held on take_action/take_no_action until cmd_ready
module nios2_cpu_debug_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    input  logic                 cmd_ready,
    input  logic                 ovf_clr,
    output logic [DATA_W-1:0]    jdo,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 busy,
    output logic                 overflow,
    output logic                 timeout
);

    localparam int N_CMD = 2**IR_W;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..65535");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SYNC_STAGES-1:0]  udr_sync;
    logic [SYNC_STAGES-1:0]  uir_sync;
    logic                    udr_d;
    logic                    uir_d;
    logic                    udr_rise;
    logic                    uir_rise;
    logic [IR_W-1:0]         ir_q;
    logic [IR_W-1:0]         ir_pend;
    logic                    ir_pend_vld;
    logic [N_CMD-1:0]        ir_sel;
    logic                    in_issue;
    logic                    cmd_ack;
    logic                    tmo_hit;
    logic                    issue_exit;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_d    <= 1'b0;
            uir_d    <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_d    <= udr_sync[SYNC_STAGES-1];
            uir_d    <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_rise   = udr_sync[SYNC_STAGES-1] & ~udr_d;
    assign uir_rise   = uir_sync[SYNC_STAGES-1] & ~uir_d;
    assign in_issue   = (state == ST_ISSUE);
    assign cmd_ack    = in_issue & cmd_ready;
    assign issue_exit = cmd_ack | tmo_hit;
    assign ir_sel     = N_CMD'(1) << ir_q;

`ifdef NIOS2_DEBUG_CMD_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Exit on the edge that would bring the count to TIMEOUT_CYC, so the strobe lasts exactly TIMEOUT_CYC cycles.
    assign tmo_hit = in_issue & ~cmd_ready & (tmo_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (!in_issue) begin
                tmo_cnt <= '0;
            end else if (!cmd_ready) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end else if (ovf_clr) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (udr_rise)   state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue_exit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        take_action    = '0;
        take_no_action = '0;
        if (in_issue) begin
            busy = 1'b1;
            if (jdo[DATA_W-1]) begin
                take_action = ir_sel;
            end else begin
                take_no_action = ir_sel;
            end
        end
    end

    // An IR update seen while a command is pending is parked and applied on exit, so the live strobe never moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            jdo         <= '0;
            ir_q        <= '0;
            ir_pend     <= '0;
            ir_pend_vld <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (!in_issue) begin
                if (uir_rise) ir_q <= ir_in;
                if (udr_rise) jdo  <= sr;
            end else begin
                if (uir_rise) begin
                    ir_pend     <= ir_in;
                    ir_pend_vld <= 1'b1;
                end
                if (issue_exit) begin
                    ir_pend_vld <= 1'b0;
                    if (uir_rise) begin
                        ir_q <= ir_in;
                    end else if (ir_pend_vld) begin
                        ir_q <= ir_pend;
                    end
                end
            end
            if (in_issue && udr_rise) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_cpu_debug_cmd_bridge.sv
// Directed bench for nios2_cpu_debug_cmd_bridge with hand-computed expectations.
// Build with NIOS2_DEBUG_CMD_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYC=8).
module tb_nios2_cpu_debug_cmd_bridge;

    localparam int DATA_W = 38;
    localparam int IR_W   = 2;
`ifdef NIOS2_DEBUG_CMD_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              vs_udr;
    logic              vs_uir;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              cmd_ready;
    logic              ovf_clr;
    logic [DATA_W-1:0] jdo;
    logic [3:0]        take_action;
    logic [3:0]        take_no_action;
    logic              busy;
    logic              overflow;
    logic              timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios2_cpu_debug_cmd_bridge #(
        .DATA_W      (DATA_W),
        .IR_W        (IR_W),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .busy           (busy),
        .overflow       (overflow),
        .timeout        (timeout)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_uir(input logic [IR_W-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        gap(3);
        vs_uir = 1'b0;
        gap(3);
    endtask

    // Raises vs_udr and returns at the negedge of the expected first strobe cycle; caller lowers vs_udr.
    task automatic send_udr(input string tag, input logic [DATA_W-1:0] d);
        sr     = d;
        vs_udr = 1'b1;
        gap(2);
        check_val({tag, "_early"}, 64'(busy), 64'd0);
        gap(1);
    endtask

    initial begin
        reset     = 1'b1;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        ir_in     = '0;
        sr        = '0;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        gap(2);
        check_val("rst_jdo",  64'(jdo),            64'd0);
        check_val("rst_busy", 64'(busy),           64'd0);
        check_val("rst_ta",   64'(take_action),    64'd0);
        check_val("rst_tna",  64'(take_no_action), 64'd0);
        check_val("rst_ovf",  64'(overflow),       64'd0);
        check_val("rst_tmo",  64'(timeout),        64'd0);
        reset = 1'b0;
        gap(1);

        // action strobe, immediate acknowledge
        cmd_ready = 1'b1;
        send_uir(2'b01);
        send_udr("act", 38'h20_0000_00AB);
        check_val("act_ta",   64'(take_action),    64'h2);
        check_val("act_tna",  64'(take_no_action), 64'h0);
        check_val("act_busy", 64'(busy),           64'd1);
        check_val("act_jdo",  64'(jdo),            64'h20_0000_00AB);
        vs_udr = 1'b0;
        gap(1);
        check_val("act_ta_end",   64'(take_action), 64'h0);
        check_val("act_busy_end", 64'(busy),        64'd0);
        gap(3);

        // no-action strobe held until cmd_ready
        cmd_ready = 1'b0;
        send_uir(2'b11);
        send_udr("hold", 38'h00_1234_5678);
        vs_udr = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check_val("hold_tna", 64'(take_no_action), 64'h8);
            check_val("hold_ta",  64'(take_action),    64'h0);
            if (i == 10) cmd_ready = 1'b1;
            gap(1);
        end
        check_val("hold_busy_end", 64'(busy),           64'd0);
        check_val("hold_tna_end",  64'(take_no_action), 64'h0);
        gap(3);

        // overflow on second update-DR while issuing
        cmd_ready = 1'b0;
        send_udr("ovf", 38'h20_0000_0055);
        vs_udr = 1'b0;
        check_val("ovf_ta", 64'(take_action), 64'h8);
        gap(2);
        sr     = 38'h1;
        vs_udr = 1'b1;
        gap(2);
        check_val("ovf_pre", 64'(overflow), 64'd0);
        gap(1);
        check_val("ovf_set",   64'(overflow),    64'd1);
        check_val("ovf_jdo",   64'(jdo),         64'h20_0000_0055);
        check_val("ovf_ta2",   64'(take_action), 64'h8);
        vs_udr    = 1'b0;
        cmd_ready = 1'b1;
        gap(1);
        check_val("ovf_busy",   64'(busy),     64'd0);
        check_val("ovf_sticky", 64'(overflow), 64'd1);
        ovf_clr = 1'b1;
        gap(1);
        ovf_clr = 1'b0;
        check_val("ovf_clr", 64'(overflow), 64'd0);
        gap(3);

        // simultaneous update-IR and update-DR use the new IR
        ir_in  = 2'b10;
        vs_uir = 1'b1;
        send_udr("simul", 38'h20_0000_0001);
        check_val("simul_ta", 64'(take_action), 64'h4);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        gap(1);
        check_val("simul_busy", 64'(busy), 64'd0);
        gap(3);

        // IR update during issue is deferred until exit
        cmd_ready = 1'b0;
        send_udr("defer", 38'h00_0000_0002);
        vs_udr = 1'b0;
        check_val("defer_tna", 64'(take_no_action), 64'h4);
        send_uir(2'b00);
        check_val("defer_tna_hold", 64'(take_no_action), 64'h4);
        check_val("defer_busy",     64'(busy),           64'd1);
        cmd_ready = 1'b1;
        gap(1);
        check_val("defer_busy_end", 64'(busy), 64'd0);
        gap(2);
        send_udr("defer2", 38'h20_0000_0003);
        check_val("defer2_ta", 64'(take_action), 64'h1);
        vs_udr = 1'b0;
        gap(4);

        // reset while issuing, vs_udr held high through reset
        cmd_ready = 1'b0;
        send_udr("rmid", 38'h20_0000_00C3);
        check_val("rmid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        gap(1);
        check_val("rmid_jdo",  64'(jdo),            64'd0);
        check_val("rmid_busy0", 64'(busy),          64'd0);
        check_val("rmid_ta",   64'(take_action),    64'd0);
        check_val("rmid_tna",  64'(take_no_action), 64'd0);
        check_val("rmid_ovf",  64'(overflow),       64'd0);
        gap(1);
        check_val("rmid_busy_rst", 64'(busy), 64'd0);
        reset = 1'b0;
        gap(2);
        check_val("rmid_post_early", 64'(busy), 64'd0);
        gap(1);
        check_val("rmid_post_busy", 64'(busy),        64'd1);
        check_val("rmid_post_jdo",  64'(jdo),         64'h20_0000_00C3);
        check_val("rmid_post_ta",   64'(take_action), 64'h1);
        vs_udr    = 1'b0;
        cmd_ready = 1'b1;
        gap(1);
        check_val("rmid_post_end", 64'(busy), 64'd0);
        gap(3);

`ifdef NIOS2_DEBUG_CMD_TIMEOUT_EN
        cmd_ready = 1'b0;
        send_udr("tmo", 38'h20_0000_0007);
        vs_udr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("tmo_busy", 64'(busy),        64'd1);
            check_val("tmo_ta",   64'(take_action), 64'h1);
            gap(1);
        end
        check_val("tmo_busy_end", 64'(busy),        64'd0);
        check_val("tmo_ta_end",   64'(take_action), 64'h0);
        check_val("tmo_flag",     64'(timeout),     64'd1);
        ovf_clr = 1'b1;
        gap(1);
        ovf_clr = 1'b0;
        check_val("tmo_clr", 64'(timeout), 64'd0);
`else
        cmd_ready = 1'b0;
        send_udr("notmo", 38'h20_0000_0007);
        vs_udr = 1'b0;
        gap(300);
        check_val("notmo_busy", 64'(busy),    64'd1);
        check_val("notmo_flag", 64'(timeout), 64'd0);
        cmd_ready = 1'b1;
        gap(1);
        check_val("notmo_end", 64'(busy), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
